// File: rtl/dehaze_axis_frame_packer.sv
// Buffers the dehaze pipeline's unthrottled pixel stream in a FWFT FIFO and
// re-emits it as an AXI4-Stream master with SOF on TUSER and line/frame TLAST.
module dehaze_axis_frame_packer #(
    parameter int unsigned IMG_WIDTH     = 512,
    parameter int unsigned IMG_HEIGHT    = 512,
    parameter int unsigned FIFO_DEPTH    = 16,
    parameter int unsigned LAST_PER_LINE = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          in_valid,
    input  logic [23:0]                   in_pixel,
    input  logic                          clear_status,
    output logic [31:0]                   M_AXIS_TDATA,
    output logic                          M_AXIS_TVALID,
    input  logic                          M_AXIS_TREADY,
    output logic                          M_AXIS_TLAST,
    output logic                          M_AXIS_TUSER,
    output logic                          overflow,
    output logic                          frame_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int unsigned RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    typedef enum logic {S_IDLE, S_STREAM} state_t;

    state_t          r_state, w_state_nxt;
    logic [23:0]     r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [LW-1:0]   r_level;
    logic [CW-1:0]   r_col;
    logic [RW-1:0]   r_row;
    logic            r_overflow, r_frame_done, w_frame_done_nxt;

    logic w_valid, w_full, w_hs, w_push, w_wr, w_drop;
    logic w_col_last, w_row_last, w_sof, w_eof;

    assign w_valid    = (r_level != '0);
    assign w_full     = (r_level == LW'(FIFO_DEPTH));
    assign w_hs       = w_valid & M_AXIS_TREADY;
    assign w_push     = enable & in_valid;
    // A push into a full FIFO is still accepted when the head leaves this cycle.
    assign w_wr       = w_push & (~w_full | w_hs);
    assign w_drop     = w_push & w_full & ~w_hs;
    assign w_col_last = (r_col == CW'(IMG_WIDTH - 1));
    assign w_row_last = (r_row == RW'(IMG_HEIGHT - 1));
    assign w_sof      = (r_col == '0) && (r_row == '0);
    assign w_eof      = w_col_last & w_row_last;

    assign M_AXIS_TVALID = w_valid;
    assign M_AXIS_TDATA  = w_valid ? {8'h00, r_mem[r_rd_ptr]} : 32'h0;
    assign M_AXIS_TUSER  = w_valid & w_sof;
    assign M_AXIS_TLAST  = w_valid & w_col_last & ((LAST_PER_LINE != 0) | w_row_last);
    assign overflow      = r_overflow;
    assign frame_done    = r_frame_done;
    assign fifo_level    = r_level;

    // Pixel storage; contents are don't-care while unoccupied.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= in_pixel;
        end
    end

    // FIFO pointers, occupancy and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_hs) r_rd_ptr <= r_rd_ptr + AW'(1);
            r_level <= r_level + LW'(w_wr) - LW'(w_hs);
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clear_status) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Framing counters follow transferred pixels only.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_hs) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + RW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_frame_done <= w_frame_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_frame_done_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_hs && w_sof) w_state_nxt = S_STREAM;
            end
            S_STREAM: begin
                if (w_hs && w_eof) begin
                    w_state_nxt      = S_IDLE;
                    w_frame_done_nxt = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_dehaze_axis_frame_packer.sv
// Directed + randomized bench for dehaze_axis_frame_packer against a queue-based
// model; two instances differ only in LAST_PER_LINE.
module tb_dehaze_axis_frame_packer;

    localparam int W = 4;
    localparam int H = 2;
    localparam int D = 4;
    localparam int FP = W * H;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic        in_valid = 1'b0;
    logic [23:0] in_pixel = '0;
    logic        clear_status = 1'b0;
    logic        tready = 1'b0;

    logic [31:0] tdata0, tdata1;
    logic        tvalid0, tvalid1, tlast0, tlast1, tuser0, tuser1;
    logic        ovf0, ovf1, fd0, fd1;
    logic [2:0]  lvl0, lvl1;

    int checks = 0;
    int errors = 0;

    logic [23:0] q[$];
    int          n_xfer = 0;
    bit          ovf_m = 0;
    bit          fd_m = 0;
    int          fd_seen = 0;

    always #5 clk = ~clk;

    dehaze_axis_frame_packer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .FIFO_DEPTH(D), .LAST_PER_LINE(0)) u0 (
        .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .in_pixel(in_pixel),
        .clear_status(clear_status), .M_AXIS_TDATA(tdata0), .M_AXIS_TVALID(tvalid0),
        .M_AXIS_TREADY(tready), .M_AXIS_TLAST(tlast0), .M_AXIS_TUSER(tuser0),
        .overflow(ovf0), .frame_done(fd0), .fifo_level(lvl0));

    dehaze_axis_frame_packer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .FIFO_DEPTH(D), .LAST_PER_LINE(1)) u1 (
        .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .in_pixel(in_pixel),
        .clear_status(clear_status), .M_AXIS_TDATA(tdata1), .M_AXIS_TVALID(tvalid1),
        .M_AXIS_TREADY(tready), .M_AXIS_TLAST(tlast1), .M_AXIS_TUSER(tuser1),
        .overflow(ovf1), .frame_done(fd1), .fifo_level(lvl1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare current outputs with the model, then advance one clock.
    task automatic step();
        bit v;
        int m;
        bit pop, push, drop, fd_new;
        v = (q.size() != 0);
        m = n_xfer % FP;
        if (fd0) fd_seen++;
        chk("tvalid0", 32'(tvalid0), 32'(v));
        chk("tvalid1", 32'(tvalid1), 32'(v));
        chk("level0", 32'(lvl0), q.size());
        chk("level1", 32'(lvl1), q.size());
        chk("overflow", 32'(ovf0), 32'(ovf_m));
        chk("frame_done0", 32'(fd0), 32'(fd_m));
        chk("frame_done1", 32'(fd1), 32'(fd_m));
        if (v) begin
            chk("tdata0", tdata0, {8'h00, q[0]});
            chk("tdata1", tdata1, {8'h00, q[0]});
            chk("tuser", 32'(tuser0), 32'(m == 0));
            chk("tlast_frame", 32'(tlast0), 32'(m == FP - 1));
            chk("tlast_line", 32'(tlast1), 32'((m % W) == W - 1));
        end
        pop  = v && tready;
        push = enable && in_valid;
        drop = 0;
        fd_new = 0;
        if (rst) begin
            q.delete();
            n_xfer = 0;
            ovf_m = 0;
        end else begin
            if (pop) begin
                fd_new = (m == FP - 1);
                void'(q.pop_front());
                n_xfer++;
            end
            if (push) begin
                if (q.size() < D || pop) q.push_back(in_pixel);
                else drop = 1;
            end
            ovf_m = drop ? 1'b1 : (clear_status ? 1'b0 : ovf_m);
        end
        fd_m = fd_new;
        @(posedge clk);
        #1;
    endtask

    task automatic push_px(input logic [23:0] px);
        in_valid = 1'b1;
        in_pixel = px;
        step();
        in_valid = 1'b0;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    initial begin
        logic [31:0] held;
        int pushed;
        int guard;

        // Reset values
        @(posedge clk); #1;
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        chk("rst_tvalid", 32'(tvalid0), 0);
        chk("rst_tdata", tdata0, 0);
        chk("rst_tlast", 32'(tlast0), 0);
        chk("rst_tuser", 32'(tuser0), 0);
        chk("rst_level", 32'(lvl0), 0);
        chk("rst_ovf", 32'(ovf0), 0);
        chk("rst_fd", 32'(fd0), 0);

        // Back-to-back frame with TREADY high
        tready = 1'b1;
        fd_seen = 0;
        for (int i = 1; i <= 8; i++) push_px(24'(i));
        idle(3);
        chk("frame1_fd_count", fd_seen, 1);

        // Stall with overflow, then drain with held-data check
        tready = 1'b0;
        for (int i = 0; i < 5; i++) push_px(24'h10 + 24'(i));
        chk("stall_level", 32'(lvl0), 4);
        chk("stall_ovf", 32'(ovf0), 1);
        held = tdata0;
        idle(3);
        chk("stall_hold", tdata0, held);
        chk("stall_head", tdata0, 32'h10);
        tready = 1'b1;
        idle(6);

        // Clear overflow, then full + pop + push in the same cycle
        clear_status = 1'b1;
        step();
        clear_status = 1'b0;
        chk("cleared_ovf", 32'(ovf0), 0);
        tready = 1'b0;
        for (int i = 0; i < 4; i++) push_px(24'h20 + 24'(i));
        tready = 1'b1;
        push_px(24'h24);
        chk("full_pop_level", 32'(lvl0), 4);
        chk("full_pop_ovf", 32'(ovf0), 0);
        idle(6);

        // Input ignored while disabled
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_px(24'h30 + 24'(i));
            step();
        end
        chk("dis_level", 32'(lvl0), 0);
        chk("dis_tvalid", 32'(tvalid0), 0);
        chk("dis_ovf", 32'(ovf0), 0);
        enable = 1'b1;

        // Reset mid-frame discards buffered pixels and restarts framing
        rst = 1'b1; step(); rst = 1'b0;
        for (int i = 0; i < 3; i++) push_px(24'h40 + 24'(i));
        idle(1);
        tready = 1'b0;
        push_px(24'h50);
        push_px(24'h51);
        rst = 1'b1; step(); rst = 1'b0;
        chk("mrst_tvalid", 32'(tvalid0), 0);
        chk("mrst_level", 32'(lvl0), 0);
        chk("mrst_tdata", tdata0, 0);
        chk("mrst_tuser", 32'(tuser0), 0);
        tready = 1'b1;
        push_px(24'h60);
        chk("mrst_next_tuser", 32'(tuser0), 1);
        chk("mrst_next_tdata", tdata0, 32'h60);
        idle(2);

        // Three frames under random TREADY
        rst = 1'b1; step(); rst = 1'b0;
        fd_seen = 0;
        pushed = 0;
        guard = 0;
        while (!(pushed == 3 * FP && q.size() == 0) && guard < 2000) begin
            tready = ($urandom % 3) != 0;
            if (pushed < 3 * FP && q.size() < D - 1 && ($urandom % 4) != 0) begin
                in_valid = 1'b1;
                in_pixel = 24'($urandom);
                pushed++;
            end else begin
                in_valid = 1'b0;
            end
            step();
            guard++;
        end
        in_valid = 1'b0;
        chk("rand_timeout", 32'(guard < 2000), 1);
        idle(2);
        chk("rand_fd_count", fd_seen, 3);
        chk("rand_xfer", n_xfer, 3 * FP);
        chk("rand_ovf", 32'(ovf0), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
